mem_ip_responder: RTL and testbench

- Memory-side responder for the EX/MEM request interface.
- Accepts the registered request (dataena, datarw, address, IP_read/IP_write flags) from the pipeline register.
- Runs the access against the synchronous data SRAM or the memory-mapped IP slave port.
- Returns a one-cycle `count` completion pulse, which the pipeline register uses to drop `dataena`. It also returns read data.

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/resp_wait_counter.sv | 32 +++
 rtl/mem_ip_responder.sv | 157 +++++++++++++++
 tb/tb_mem_ip_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the EX/MEM memory/IP responder: FSM encoding,
// abort read-data pattern and default widths.
package mem_resp_pkg;

    localparam int ADDR_W_DEF      = 20;
    localparam int DATA_W_DEF      = 32;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int IP_TIMEOUT_DEF  = 15;

    // Counter widths sized for the legal parameter ranges (1..15, 1..255)
    localparam int WAIT_CNT_W = 4;
    localparam int TOUT_CNT_W = 8;

    localparam logic [31:0] RESP_ERR_DATA = 32'hDEADBEEF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MEM_REQ  = 3'd1;
    localparam logic [2:0] ST_MEM_WAIT = 3'd2;
    localparam logic [2:0] ST_IP_REQ   = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/resp_wait_counter.sv
// Loadable down-counter; 'last' flags the final cycle of the loaded span.
module resp_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_ip_responder.sv
// Memory-side responder: runs one latched EX/MEM request against the SRAM or
// the IP slave port and returns a single-cycle 'count' completion pulse.
module mem_ip_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int IP_TIMEOUT  = IP_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dataena_in,
    input  logic              datarw_in,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              ip_read_in,
    input  logic              ip_write_in,
    output logic              count,
    output logic [DATA_W-1:0] rdata_out,
    output logic              busy,
    output logic              err_out,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ip_cs,
    output logic              ip_we,
    output logic [ADDR_W-1:0] ip_addr,
    output logic [DATA_W-1:0] ip_wdata,
    input  logic [DATA_W-1:0] ip_rdata,
    input  logic              ip_ack
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              mem_first_q, mem_first_d;

    logic wait_load, wait_last;
    logic tout_load, tout_last;
    logic ip_sel;

    assign ip_sel = ip_read_in | ip_write_in;

    resp_wait_counter #(.CNT_W(WAIT_CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
        .dec      (state_q == ST_MEM_WAIT),
        .last     (wait_last)
    );

    resp_wait_counter #(.CNT_W(TOUT_CNT_W)) u_tout_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (tout_load),
        .load_val (TOUT_CNT_W'(IP_TIMEOUT)),
        .dec      (state_q == ST_IP_REQ),
        .last     (tout_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        we_d        = we_q;
        err_d       = err_q;
        mem_first_d = (state_q == ST_MEM_REQ);
        wait_load   = 1'b0;
        tout_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dataena_in) begin
                    addr_d    = address_in;
                    wdata_d   = wdata_in;
                    // Conflicting flags resolve to an IP write, reported as an error
                    we_d      = ip_sel ? ip_write_in : datarw_in;
                    err_d     = ip_read_in & ip_write_in;
                    tout_load = ip_sel;
                    state_d   = ip_sel ? ST_IP_REQ : ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                wait_load = 1'b1;
                state_d   = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                // SRAM read data is only valid in the cycle right after mem_cs
                if (mem_first_q && !we_q)
                    rdata_d = mem_rdata;
                if (wait_last)
                    state_d = ST_DONE;
            end
            ST_IP_REQ: begin
                if (ip_ack) begin
                    if (!we_q)
                        rdata_d = ip_rdata;
                    state_d = ST_DONE;
                end else if (tout_last) begin
                    rdata_d = DATA_W'(RESP_ERR_DATA);
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            we_q        <= we_d;
            err_q       <= err_d;
            mem_first_q <= mem_first_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign count     = (state_q == ST_DONE);
    assign err_out   = count & err_q;
    assign rdata_out = rdata_q;

    assign mem_cs    = (state_q == ST_MEM_REQ);
    assign mem_we    = mem_cs & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign ip_cs     = (state_q == ST_IP_REQ);
    assign ip_we     = ip_cs & we_q;
    assign ip_addr   = addr_q;
    assign ip_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_ip_responder.sv
// Directed bench: each request is turned into expected windows (busy, chip
// selects, count cycle, read-data change) from the latency rules, and a
// negedge process compares every cycle.
module tb_mem_ip_responder;

    localparam int AW  = 20;
    localparam int DW  = 32;
    localparam int W   = 2;
    localparam int T   = 15;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dataena_in = 1'b0, datarw_in = 1'b0;
    logic [AW-1:0] address_in = '0;
    logic [DW-1:0] wdata_in = '0;
    logic          ip_read_in = 1'b0, ip_write_in = 1'b0;
    logic          count, busy, err_out, mem_cs, mem_we, ip_cs, ip_we;
    logic [DW-1:0] rdata_out, mem_wdata, ip_wdata;
    logic [AW-1:0] mem_addr, ip_addr;
    logic [DW-1:0] mem_rdata = '0, ip_rdata = '0;
    logic          ip_ack = 1'b0;

    mem_ip_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .IP_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .dataena_in(dataena_in), .datarw_in(datarw_in),
        .address_in(address_in), .wdata_in(wdata_in), .ip_read_in(ip_read_in),
        .ip_write_in(ip_write_in), .count(count), .rdata_out(rdata_out), .busy(busy),
        .err_out(err_out), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ip_cs(ip_cs), .ip_we(ip_we),
        .ip_addr(ip_addr), .ip_wdata(ip_wdata), .ip_rdata(ip_rdata), .ip_ack(ip_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;
    bit chk_en = 1'b0;

    // Expected-behaviour plan for the request in flight
    int            a_g = -100, busy_lo = -100, cnt_cyc = -100, mem_cyc = -100;
    int            ip_lo = -100, ip_hi = -101, ack_cyc = -100, rd_chg = BIG;
    bit            wr_g = 1'b0, err_g = 1'b0;
    logic [AW-1:0] addr_g = '0;
    logic [DW-1:0] wd_g = '0, rd_data_g = '0;
    logic [DW-1:0] rd_cur = '0, rd_next = '0, model_rd = '0;
    int            last_count_cyc = -1;
    logic          last_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            automatic int c = cyc;
            automatic bit e_mem = (c == mem_cyc);
            automatic bit e_ip  = (c >= ip_lo) && (c <= ip_hi);
            automatic bit e_cnt = (c == cnt_cyc);
            chk("busy",      busy,      (c >= busy_lo) && (c <= cnt_cyc));
            chk("mem_cs",    mem_cs,    e_mem);
            chk("mem_we",    mem_we,    e_mem && wr_g);
            chk("ip_cs",     ip_cs,     e_ip);
            chk("ip_we",     ip_we,     e_ip && wr_g);
            chk("count",     count,     e_cnt);
            chk("err_out",   err_out,   e_cnt && err_g);
            chk("rdata_out", rdata_out, (c >= rd_chg) ? rd_next : rd_cur);
            if (e_mem) begin
                chk("mem_addr",  mem_addr,  addr_g);
                chk("mem_wdata", mem_wdata, wd_g);
            end
            if (e_ip) begin
                chk("ip_addr",  ip_addr,  addr_g);
                chk("ip_wdata", ip_wdata, wd_g);
            end
            if (count) begin
                last_count_cyc = c;
                last_err = err_out;
            end
        end
    end

    // Called at posedge+1 of the acceptance cycle; drives the request and plans outputs.
    task automatic start_req(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input bit ipr, input bit ipw, input int ack_d,
                             input logic [DW-1:0] rdv, output int acc);
        automatic bit ip = ipr | ipw;
        acc = cyc;
        dataena_in = 1'b1; datarw_in = rw; address_in = addr; wdata_in = wd;
        ip_read_in = ipr; ip_write_in = ipw;
        a_g = acc; addr_g = addr; wd_g = wd; rd_data_g = rdv;
        wr_g = ip ? ipw : rw;
        err_g = ipr & ipw;
        rd_cur = model_rd; rd_next = model_rd; rd_chg = BIG;
        busy_lo = acc + 1;
        ack_cyc = -100;
        if (!ip) begin
            mem_cyc = acc + 1; ip_lo = -100; ip_hi = -101;
            cnt_cyc = acc + 2 + W;
            if (!rw) begin rd_next = rdv; rd_chg = acc + 3; end
        end else begin
            mem_cyc = -100; ip_lo = acc + 1;
            if (ack_d >= 0 && ack_d < T) begin
                ack_cyc = acc + 1 + ack_d;
                ip_hi = ack_cyc;
                if (!wr_g) begin rd_next = rdv; rd_chg = ip_hi + 1; end
            end else begin
                ip_hi = acc + T;
                err_g = 1'b1;
                rd_next = 32'hDEADBEEF; rd_chg = ip_hi + 1;
            end
            cnt_cyc = ip_hi + 1;
        end
    endtask

    task automatic finish_req();
        automatic int c;
        do begin
            @(posedge clk); #1;
            c = cyc;
            mem_rdata = (c == a_g + 2) ? rd_data_g : $urandom;
            ip_ack    = (c == ack_cyc);
            ip_rdata  = (c == ack_cyc) ? rd_data_g : $urandom;
            if (c == a_g + 1) begin
                // Request inputs must be ignored once accepted
                datarw_in = ~datarw_in; address_in = $urandom; wdata_in = $urandom;
                ip_read_in = ~ip_read_in; ip_write_in = ~ip_write_in;
            end
            if (c == cnt_cyc + 1) dataena_in = 1'b0;
        end while (c <= cnt_cyc);
        ip_ack = 1'b0;
        if (rd_chg != BIG) model_rd = rd_next;
    endtask

    task automatic run_req(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input bit ipr, input bit ipw, input int ack_d,
                           input logic [DW-1:0] rdv, output int acc);
        @(posedge clk); #1;
        start_req(rw, addr, wd, ipr, ipw, ack_d, rdv, acc);
        finish_req();
    endtask

    initial begin
        automatic int acc;
        repeat (2) @(negedge clk);
        chk("rst_count", count, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_cs", mem_cs, 1'b0);
        chk("rst_ip_cs", ip_cs, 1'b0);
        chk("rst_err", err_out, 1'b0);
        chk("rst_rdata", rdata_out, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // 1: memory read
        run_req(1'b0, 20'h00040, 32'h0, 1'b0, 1'b0, -1, 32'h12345678, acc);
        chk("t1_latency", last_count_cyc - acc, 4);
        chk("t1_rdata", rdata_out, 32'h12345678);
        chk("t1_err", last_err, 1'b0);

        // 2: memory write
        run_req(1'b1, 20'h00100, 32'hCAFEF00D, 1'b0, 1'b0, -1, 32'h99999999, acc);
        chk("t2_latency", last_count_cyc - acc, 4);
        chk("t2_rdata", rdata_out, 32'h12345678);

        // 3: IP read, ack 3 cycles after ip_cs rises
        run_req(1'b0, 20'h00200, 32'h0, 1'b1, 1'b0, 3, 32'h0000ABCD, acc);
        chk("t3_latency", last_count_cyc - acc, 5);
        chk("t3_rdata", rdata_out, 32'h0000ABCD);

        // 4: IP write, no ack -> timeout
        run_req(1'b1, 20'h00300, 32'h11223344, 1'b0, 1'b1, -1, 32'h0, acc);
        chk("t4_latency", last_count_cyc - acc, 16);
        chk("t4_err", last_err, 1'b1);
        chk("t4_rdata", rdata_out, 32'hDEADBEEF);

        // 5: both IP flags -> IP write with error
        run_req(1'b0, 20'h00404, 32'h5A5A0001, 1'b1, 1'b1, 1, 32'h77777777, acc);
        chk("t5_latency", last_count_cyc - acc, 3);
        chk("t5_err", last_err, 1'b1);
        chk("t5_rdata", rdata_out, 32'hDEADBEEF);

        // Ack coincident with the timeout cycle: ack wins
        run_req(1'b0, 20'h00500, 32'h0, 1'b1, 1'b0, T - 1, 32'h00C0FFEE, acc);
        chk("tb_latency", last_count_cyc - acc, 16);
        chk("tb_err", last_err, 1'b0);
        chk("tb_rdata", rdata_out, 32'h00C0FFEE);

        // Ack on the first IP_REQ cycle
        run_req(1'b0, 20'hFFFFF, 32'h0, 1'b1, 1'b0, 0, 32'hFEDCBA98, acc);
        chk("t0_latency", last_count_cyc - acc, 2);

        // 6: reset during MEM_WAIT, then fresh access with dataena held high
        @(posedge clk); #1;
        start_req(1'b0, 20'h00600, 32'h0, 1'b0, 1'b0, -1, 32'h55AA55AA, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_mem_cs", mem_cs, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_count", count, 1'b0);
        chk("t6_rdata", rdata_out, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_rd = '0;
        last_count_cyc = -1;
        start_req(1'b0, 20'h00700, 32'h0, 1'b0, 1'b0, -1, 32'h0BADF00D, acc);
        chk_en = 1'b1;
        finish_req();
        chk("t6_latency", last_count_cyc - acc, 4);
        chk("t6_rdata2", rdata_out, 32'h0BADF00D);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
